ex_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit in the EX stage; consumes operands and decoded op from the ID/EX register.

---
 rtl/ex_muldiv_unit.sv | 116 +++++++++++
 tb/tb_ex_muldiv_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MIPS mult/multu/div/divu unit with architectural HI/LO
// Ports:
//   clk, reset (async, active-high)
//   i_start, i_op[1:0] (00 mult, 01 multu, 10 div, 11 divu), i_src_a, i_src_b
//   i_hilo_use, i_wr_hi, i_wr_lo, i_wr_data   mfhi/mflo/mthi/mtlo interface
//   o_hi, o_lo                               HI/LO registers
//   o_busy, o_done, o_stall_req               status to the pipeline / hazard unit
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    input  logic             i_hilo_use,
    input  logic             i_wr_hi,
    input  logic             i_wr_lo,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_stall_req
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic {IDLE, BUSY} state_t;
    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               w_a_neg, w_b_neg, w_last, w_ok, w_div0;
    logic [WIDTH-1:0]   w_a_abs, w_b_abs, w_nacc, w_nq, w_quo, w_rem, w_res_hi, w_res_lo;
    logic [WIDTH:0]     w_sum, w_sh;
    logic [2*WIDTH-1:0] w_prod, w_prod_s;
    // signed ops are the ones with op[0]==0 (mult, div)
    assign w_a_neg = ~i_op[0] & i_src_a[WIDTH-1];
    assign w_b_neg = ~i_op[0] & i_src_b[WIDTH-1];
    assign w_a_abs = w_a_neg ? -i_src_a : i_src_a;
    assign w_b_abs = w_b_neg ? -i_src_b : i_src_b;
    // multiply: {r_acc, r_q} is the product register, r_q starts as the multiplier
    assign w_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
    // divide: {r_acc, r_q} shifts left, r_q starts as the dividend and fills with quotient bits
    assign w_sh  = {r_acc, r_q[WIDTH-1]};
    assign w_ok  = w_sh >= {1'b0, r_m};
    // when the subtract succeeds the difference is below the divisor, so WIDTH bits suffice
    assign w_nacc = r_div ? (w_ok ? w_sh[WIDTH-1:0] - r_m : w_sh[WIDTH-1:0]) : w_sum[WIDTH:1];
    assign w_nq   = r_div ? {r_q[WIDTH-2:0], w_ok} : {w_sum[0], r_q[WIDTH-1:1]};
    assign w_prod   = {w_nacc, w_nq};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quo    = r_neg_q ? -w_nq : w_nq;
    assign w_rem    = r_neg_r ? -w_nacc : w_nacc;
    assign w_div0   = r_m == '0;
    // divide-by-zero bypasses sign correction: all-ones quotient, raw dividend as remainder
    assign w_res_hi = !r_div ? w_prod_s[2*WIDTH-1:WIDTH] : w_div0 ? r_a_raw : w_rem;
    assign w_res_lo = !r_div ? w_prod_s[WIDTH-1:0] : w_div0 ? '1 : w_quo;
    assign w_last   = r_cnt == CW'(WIDTH - 1);
    assign o_busy      = r_state == BUSY;
    assign o_stall_req = o_busy & (i_start | i_hilo_use);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_done = r_done;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_a_raw <= '0;
            r_m     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // mthi/mtlo first so a completing mul/div overrides them below
            if (!o_stall_req && i_wr_hi) r_hi <= i_wr_data;
            if (!o_stall_req && i_wr_lo) r_lo <= i_wr_data;
            if (r_state == IDLE) begin
                if (i_start) begin
                    r_state <= BUSY;
                    r_cnt   <= '0;
                    r_div   <= i_op[1];
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= w_a_neg;
                    r_a_raw <= i_src_a;
                    r_m     <= i_op[1] ? w_b_abs : w_a_abs;
                    r_q     <= i_op[1] ? w_a_abs : w_b_abs;
                    r_acc   <= '0;
                end
            end else begin
                r_acc <= w_nacc;
                r_q   <= w_nq;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_state <= IDLE;
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_done  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;
    logic        clk, reset;
    logic        i_start, i_hilo_use, i_wr_hi, i_wr_lo;
    logic [1:0]  i_op;
    logic [31:0] i_src_a, i_src_b, i_wr_data;
    logic [31:0] o_hi, o_lo;
    logic        o_busy, o_done, o_stall_req;
    int checks = 0;
    int errors = 0;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_op(i_op),
        .i_src_a(i_src_a), .i_src_b(i_src_b), .i_hilo_use(i_hilo_use),
        .i_wr_hi(i_wr_hi), .i_wr_lo(i_wr_lo), .i_wr_data(i_wr_data),
        .o_hi(o_hi), .o_lo(o_lo), .o_busy(o_busy), .o_done(o_done),
        .o_stall_req(o_stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string nm);
        int n;
        i_start = 1'b1; i_op = op; i_src_a = a; i_src_b = b;
        tick();
        i_start = 1'b0;
        n = 0;
        while (o_busy && n < 100) begin n++; tick(); end
        checks++; if (n !== 32) begin errors++; $display("FAIL %s busy_cycles: got %0d expected 32", nm, n); end
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL %s done: got %b expected 1", nm, o_done); end
        checks++; if (o_hi !== eh) begin errors++; $display("FAIL %s hi: got %h expected %h", nm, o_hi, eh); end
        checks++; if (o_lo !== el) begin errors++; $display("FAIL %s lo: got %h expected %h", nm, o_lo, el); end
        tick();
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL %s done_pulse: got %b expected 0", nm, o_done); end
    endtask

    task automatic test_reset;
        #1;
        checks++; if (o_hi !== 32'h0) begin errors++; $display("FAIL reset hi: got %h expected 0", o_hi); end
        checks++; if (o_lo !== 32'h0) begin errors++; $display("FAIL reset lo: got %h expected 0", o_lo); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", o_done); end
        @(posedge clk); #3; reset = 1'b0;
        tick();
    endtask

    task automatic test_mthi_mtlo;
        i_hilo_use = 1'b1; i_wr_hi = 1'b1; i_wr_data = 32'h0000_1234;
        #1;
        checks++; if (o_stall_req !== 1'b0) begin errors++; $display("FAIL idle_stall: got %b expected 0", o_stall_req); end
        tick();
        checks++; if (o_hi !== 32'h1234) begin errors++; $display("FAIL mthi hi: got %h expected 00001234", o_hi); end
        checks++; if (o_lo !== 32'h0) begin errors++; $display("FAIL mthi lo: got %h expected 0", o_lo); end
        i_wr_hi = 1'b0; i_wr_lo = 1'b1; i_wr_data = 32'h0000_5678;
        tick();
        checks++; if (o_lo !== 32'h5678) begin errors++; $display("FAIL mtlo lo: got %h expected 00005678", o_lo); end
        checks++; if (o_hi !== 32'h1234) begin errors++; $display("FAIL mtlo hi: got %h expected 00001234", o_hi); end
        i_wr_lo = 1'b0; i_hilo_use = 1'b0;
    endtask

    task automatic test_mul;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        run_op(2'b00, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg7x3");
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, "mult_intmin_sq");
    endtask

    task automatic test_div;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2");
        run_op(2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, "divu_by0");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_intmin_m1");
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_neg_by0");
    endtask

    task automatic test_stall_mflo;
        int n, bad, chg;
        logic [31:0] plo;
        plo = o_lo;
        i_start = 1'b1; i_op = 2'b00; i_src_a = 32'd5; i_src_b = 32'hFFFF_FFFA;
        tick();
        i_start = 1'b0; i_hilo_use = 1'b1;
        #1;
        n = 0; bad = 0; chg = 0;
        while (o_busy && n < 100) begin
            if (o_stall_req !== 1'b1) bad++;
            if (o_lo !== plo) chg++;
            n++;
            tick();
        end
        checks++; if (n !== 32) begin errors++; $display("FAIL stall busy_cycles: got %0d expected 32", n); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_while_busy: %0d cycles without stall expected 0", bad); end
        checks++; if (chg !== 0) begin errors++; $display("FAIL lo_stable_busy: %0d cycles changed expected 0", chg); end
        checks++; if (o_stall_req !== 1'b0) begin errors++; $display("FAIL stall_on_done: got %b expected 0", o_stall_req); end
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL stall done: got %b expected 1", o_done); end
        checks++; if (o_lo !== 32'hFFFF_FFE2) begin errors++; $display("FAIL mflo lo: got %h expected ffffffe2", o_lo); end
        i_hilo_use = 1'b0;
        tick();
    endtask

    task automatic test_busy_write;
        int n, chg;
        logic [31:0] phi;
        phi = o_hi;
        i_start = 1'b1; i_op = 2'b11; i_src_a = 32'd50; i_src_b = 32'd7;
        tick();
        i_start = 1'b0; i_hilo_use = 1'b1; i_wr_hi = 1'b1; i_wr_data = 32'hDEAD_BEEF;
        n = 0; chg = 0;
        while (o_busy && n < 100) begin
            if (o_hi !== phi) chg++;
            n++;
            tick();
        end
        checks++; if (chg !== 0) begin errors++; $display("FAIL mthi_blocked: %0d cycles changed expected 0", chg); end
        checks++; if (o_hi !== 32'd1) begin errors++; $display("FAIL divu50_7 hi: got %h expected 1", o_hi); end
        checks++; if (o_lo !== 32'd7) begin errors++; $display("FAIL divu50_7 lo: got %h expected 7", o_lo); end
        tick();
        checks++; if (o_hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_after_stall: got %h expected deadbeef", o_hi); end
        i_hilo_use = 1'b0; i_wr_hi = 1'b0;
    endtask

    task automatic test_same_edge;
        int n;
        i_start = 1'b1; i_op = 2'b00; i_src_a = 32'd2; i_src_b = 32'd3;
        i_wr_lo = 1'b1; i_wr_data = 32'h0000_ABCD;
        tick();
        i_start = 1'b0; i_wr_lo = 1'b0;
        checks++; if (o_lo !== 32'hABCD) begin errors++; $display("FAIL same_edge_mtlo: got %h expected 0000abcd", o_lo); end
        n = 0;
        while (o_busy && n < 100) begin n++; tick(); end
        checks++; if (o_lo !== 32'd6 || o_hi !== 32'd0) begin errors++; $display("FAIL same_edge_result: got %h_%h expected 0_6", o_hi, o_lo); end
        tick();
    endtask

    task automatic test_back_to_back;
        int n, bad;
        i_start = 1'b1; i_op = 2'b01; i_src_a = 32'd3; i_src_b = 32'd4;
        tick();
        i_op = 2'b11; i_src_a = 32'd100; i_src_b = 32'd7;
        n = 0; bad = 0;
        while (o_busy && n < 100) begin
            if (o_stall_req !== 1'b1) bad++;
            n++;
            tick();
        end
        checks++; if (n !== 32) begin errors++; $display("FAIL b2b first busy_cycles: got %0d expected 32", n); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2b start_stall: %0d cycles without stall expected 0", bad); end
        checks++; if (o_hi !== 32'd0 || o_lo !== 32'd12) begin errors++; $display("FAIL b2b first result: got %h_%h expected 0_c", o_hi, o_lo); end
        checks++; if (o_stall_req !== 1'b0) begin errors++; $display("FAIL b2b stall_idle: got %b expected 0", o_stall_req); end
        tick();
        i_start = 1'b0;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL b2b second accept: busy got %b expected 1", o_busy); end
        n = 0;
        while (o_busy && n < 100) begin n++; tick(); end
        checks++; if (n !== 32) begin errors++; $display("FAIL b2b second busy_cycles: got %0d expected 32", n); end
        checks++; if (o_hi !== 32'd2 || o_lo !== 32'd14) begin errors++; $display("FAIL b2b second result: got %h_%h expected 2_e", o_hi, o_lo); end
        tick();
    endtask

    task automatic test_reset_mid;
        i_start = 1'b1; i_op = 2'b10; i_src_a = 32'h0000_1000; i_src_b = 32'd3;
        tick();
        i_start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL mid_div busy: got %b expected 1", o_busy); end
        reset = 1'b1;
        #1;
        checks++; if (o_hi !== 32'h0 || o_lo !== 32'h0) begin errors++; $display("FAIL async_reset hilo: got %h_%h expected 0_0", o_hi, o_lo); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL async_reset busy: got %b expected 0", o_busy); end
        @(posedge clk); #3; reset = 1'b0;
        tick();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL post_reset busy: got %b expected 0", o_busy); end
        run_op(2'b00, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'h0, 32'h0000_2710, "mult_after_reset");
    endtask

    initial begin
        reset = 1'b1; i_start = 1'b0; i_op = 2'b00; i_src_a = '0; i_src_b = '0;
        i_hilo_use = 1'b0; i_wr_hi = 1'b0; i_wr_lo = 1'b0; i_wr_data = '0;
        test_reset();
        test_mthi_mtlo();
        test_mul();
        test_div();
        test_stall_mflo();
        test_busy_write();
        test_same_edge();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
